// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - one master's request/response port into the RAM arbiter
interface ram_arbiter_if;
  logic        req;
  logic        we;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master single-port RAM arbiter with round-robin and bounded lock bursts
// Grants are combinational; responses are registered one cycle after the grant.
module ram_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int RAM_WORDS = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  output logic          ram_we,
  output logic [31:0]   ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam int          CW    = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0] CONE  = CW'(1);
  localparam logic [31:0] WORDS = 32'(RAM_WORDS);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;

  logic          gnt0, gnt1, any_gnt;
  logic          sel_we, sel_lock, other_req, in_range, owner_cont;
  logic [31:0]   sel_addr, sel_wdata;
  logic [CW-1:0] cnt_inc;

  logic          rvalid0_q, rvalid1_q, err0_q, err1_q;
  logic [31:0]   rdata0_q, rdata1_q;

  // Grant decision; reset forces both grants low so nothing reaches the RAM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (m0.req && m1.req) begin
            gnt0 = last;
            gnt1 = !last;
          end else begin
            gnt0 = m0.req;
            gnt1 = m1.req;
          end
        end
        OWN0: begin
          gnt0 = m0.req;
          gnt1 = !m0.req && m1.req;
        end
        OWN1: begin
          gnt1 = m1.req;
          gnt0 = !m1.req && m0.req;
        end
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    any_gnt    = gnt0 || gnt1;
    sel_addr   = gnt1 ? m1.addr  : m0.addr;
    sel_wdata  = gnt1 ? m1.wdata : m0.wdata;
    sel_we     = gnt1 ? m1.we    : m0.we;
    sel_lock   = gnt1 ? m1.lock  : m0.lock;
    other_req  = gnt1 ? m0.req   : m1.req;
    in_range   = {2'b00, sel_addr[31:2]} < WORDS;
    owner_cont = (state == OWN0 && gnt0) || (state == OWN1 && gnt1);
    cnt_inc    = (cnt >= CMAX) ? CMAX : cnt + CONE;
  end

  assign ram_addr  = sel_addr;
  assign ram_wdata = sel_wdata;
  assign ram_we    = any_gnt && sel_we && in_range;

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.err    = err0_q;
  assign m1.err    = err1_q;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      err0_q    <= gnt0 && !in_range;
      err1_q    <= gnt1 && !in_range;
      rdata0_q  <= (gnt0 && in_range && !sel_we) ? ram_rdata : 32'h0;
      rdata1_q  <= (gnt1 && in_range && !sel_we) ? ram_rdata : 32'h0;

      if (!any_gnt) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        last <= gnt1;
        if (owner_cont) begin
          // The owner keeps the RAM unless it unlocks or has used up its burst while the other waits.
          if (sel_lock && !(cnt_inc == CMAX && other_req)) begin
            cnt <= cnt_inc;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end else if (sel_lock) begin
          state <= gnt1 ? OWN1 : OWN0;
          cnt   <= CONE;
        end else begin
          state <= IDLE;
          cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and random checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;
  localparam int MAX_BURST = 4;
  localparam int RAM_WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  ram_arbiter_if m0_if ();
  ram_arbiter_if m1_if ();

  ram_arbiter #(.MAX_BURST(MAX_BURST), .RAM_WORDS(RAM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Environment RAM seen by the DUT; unwritten words read their seeded value.
  logic [31:0] ram_mem [RAM_WORDS];
  bit          written [RAM_WORDS];
  assign ram_rdata = written[ram_addr[13:2]] ? ram_mem[ram_addr[13:2]] : init_val(int'(ram_addr[13:2]));
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr[13:2]] <= ram_wdata;
      written[ram_addr[13:2]] <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [RAM_WORDS];
  int          mdl_owner, mdl_burst, mdl_last, last_g;
  logic        exp_rv [2];
  logic        exp_err [2];
  logic [31:0] exp_rd [2];
  int          n_checks = 0;
  int          n_fail = 0;
  int          hist [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_owner = -1;
    mdl_burst = 0;
    mdl_last  = 1;
    for (int k = 0; k < 2; k++) begin
      exp_rv[k]  = 1'b0;
      exp_err[k] = 1'b0;
      exp_rd[k]  = 32'h0;
    end
  endtask

  task automatic step(input logic r0, input logic w0, input logic l0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1);
    logic [1:0]  req;
    logic [1:0]  lock;
    logic        gwe, inr;
    logic [31:0] ga, gd;
    int          g, idx;
    req  = {r1, r0};
    lock = {l1, l0};
    m0_if.req = r0; m0_if.we = w0; m0_if.lock = l0; m0_if.addr = a0; m0_if.wdata = d0;
    m1_if.req = r1; m1_if.we = w1; m1_if.lock = l1; m1_if.addr = a1; m1_if.wdata = d1;
    #1;
    if (mdl_owner >= 0 && req[mdl_owner]) g = mdl_owner;
    else if (mdl_owner >= 0) g = req[1 - mdl_owner] ? 1 - mdl_owner : -1;
    else if (req == 2'b11) g = 1 - mdl_last;
    else if (req[0]) g = 0;
    else if (req[1]) g = 1;
    else g = -1;
    ga  = (g == 1) ? a1 : a0;
    gd  = (g == 1) ? d1 : d0;
    gwe = (g == 1) ? w1 : w0;
    inr = (ga >> 2) < 32'(RAM_WORDS);
    idx = int'(ga[13:2]);

    chk("m0_gnt", {31'b0, m0_if.gnt}, {31'b0, g == 0});
    chk("m1_gnt", {31'b0, m1_if.gnt}, {31'b0, g == 1});
    chk("ram_we", {31'b0, ram_we}, {31'b0, (g >= 0) && gwe && inr});
    chk("ram_addr", ram_addr, ga);
    chk("ram_wdata", ram_wdata, gd);
    chk("m0_rvalid", {31'b0, m0_if.rvalid}, {31'b0, exp_rv[0]});
    chk("m1_rvalid", {31'b0, m1_if.rvalid}, {31'b0, exp_rv[1]});
    chk("m0_err", {31'b0, m0_if.err}, {31'b0, exp_err[0]});
    chk("m1_err", {31'b0, m1_if.err}, {31'b0, exp_err[1]});
    chk("m0_rdata", m0_if.rdata, exp_rd[0]);
    chk("m1_rdata", m1_if.rdata, exp_rd[1]);

    for (int k = 0; k < 2; k++) begin
      exp_rv[k]  = (g == k);
      exp_err[k] = (g == k) && !inr;
      exp_rd[k]  = ((g == k) && inr && !gwe) ? ref_mem[idx] : 32'h0;
    end
    if (g >= 0 && gwe && inr) ref_mem[idx] = gd;

    if (g < 0) begin
      mdl_owner = -1;
      mdl_burst = 0;
    end else begin
      mdl_last = g;
      if (g == mdl_owner) begin
        mdl_burst = (mdl_burst + 1 > MAX_BURST) ? MAX_BURST : mdl_burst + 1;
        if (!lock[g] || (mdl_burst == MAX_BURST && req[1 - g])) begin
          mdl_owner = -1;
          mdl_burst = 0;
        end
      end else if (lock[g]) begin
        mdl_owner = g;
        mdl_burst = 1;
      end else begin
        mdl_owner = -1;
        mdl_burst = 0;
      end
    end
    last_g = g;
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'b0, m1_if.gnt, m0_if.gnt}, 32'h0);
    chk({tag, "_ram_we"}, {31'b0, ram_we}, 32'h0);
    chk({tag, "_rvalid"}, {30'b0, m1_if.rvalid, m0_if.rvalid}, 32'h0);
    chk({tag, "_err"}, {30'b0, m1_if.err, m0_if.err}, 32'h0);
    chk({tag, "_rdata"}, m0_if.rdata | m1_if.rdata, 32'h0);
  endtask

  initial begin
    logic [31:0] a0, a1;
    rst_n = 1'b0;
    for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = init_val(i);
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.lock = 1'b0; m0_if.addr = 32'h0; m0_if.wdata = 32'h0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.lock = 1'b0; m1_if.addr = 32'h0; m1_if.wdata = 32'h0;
    model_reset();

    // Reset state with both masters requesting
    @(negedge clk);
    m0_if.req = 1'b1;
    m1_if.req = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesting without lock alternate, m0 first
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'(i * 4), 32'h0, 1'b1, 1'b0, 1'b0, 32'(i * 8), 32'h0);
      chk("alternate_grant", 32'(last_g), 32'(i % 2));
    end

    // m1 writes, m0 reads the same word back
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
    step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd_after_wr_rvalid", {31'b0, m0_if.rvalid}, 32'h1);
    chk("rd_after_wr_rdata", m0_if.rdata, 32'hDEADBEEF);
    idle_step();

    // m1 locked burst is cut at MAX_BURST while m0 waits
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 32'(32'h200 + i * 4), 32'h0);
      hist[i] = last_g;
    end
    for (int i = 0; i < 4; i++) chk("burst_m1", 32'(hist[i]), 32'h1);
    chk("burst_then_m0", 32'(hist[4]), 32'h0);
    idle_step();
    idle_step();

    // Out-of-range write by m0 (word RAM_WORDS)
    step(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("oor_rvalid", {31'b0, m0_if.rvalid}, 32'h1);
    chk("oor_err", {31'b0, m0_if.err}, 32'h1);
    chk("oor_rdata", m0_if.rdata, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle_step();

    // Reset asserted while m1 owns the RAM
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h84, 32'h0);
    chk("own1_held", 32'(last_g), 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    chk("post_rst_m0_first", 32'(last_g), 32'h0);
    idle_step();
    idle_step();

    // m1 drops req in OWN1; m0 takes over and locks
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h24, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("handover_m0", 32'(last_g), 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h28, 32'h0, 1'b1, 1'b0, 1'b0, 32'h2C, 32'h0);
    chk("own0_kept", 32'(last_g), 32'h0);
    idle_step();

    // Random traffic over a small address window with occasional out-of-range addresses
    for (int i = 0; i < 400; i++) begin
      a0 = ($urandom_range(0, 9) == 0) ? 32'h4000 + ($urandom & 32'hFFFF) : {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
      a1 = ($urandom_range(0, 9) == 0) ? 32'h4000 + ($urandom & 32'hFFFF) : {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0), a0, $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0), a1, $urandom);
    end
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: max consecutive locked grants to one master while the other master waits.
REQ-002 Parameter RAM_WORDS, default 4096: RAM depth in 32-bit words; valid byte addresses are 0 .. 4*RAM_WORDS-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 m0_req_i / m1_req_i  input  1  access request; master 0 is fetch, master 1 is load/store.
REQ-006 m0_we_i / m1_we_i  input  1  1 = write, 0 = read.
REQ-007 m0_lock_i / m1_lock_i  input  1  request to keep ownership for the next access.
REQ-008 m0_addr_i / m1_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-009 m0_wdata_i / m1_wdata_i  input  32  write data.
REQ-010 m0_gnt_o / m1_gnt_o  output  1  access accepted this cycle.
REQ-011 m0_rvalid_o / m1_rvalid_o  output  1  response valid; pulses one cycle after the grant.
REQ-012 m0_err_o / m1_err_o  output  1  out-of-range address; qualified by rvalid.
REQ-013 m0_rdata_o / m1_rdata_o  output  32  registered read data; 0 for writes and errors.
REQ-014 ram_we_o  output  1  RAM write enable.
REQ-015 ram_addr_o  output  32  RAM byte address.
REQ-016 ram_wdata_o  output  32  RAM write data.
REQ-017 ram_rdata_i  input  32  RAM combinational read data for ram_addr_o.

Function
REQ-018 The block SHALL grant at most one master per cycle; a grant is gnt high with req high in the same cycle.
REQ-019 ram_addr_o and ram_wdata_o SHALL combinationally follow the granted master's inputs; with no grant they SHALL follow master 0 and ram_we_o SHALL be 0.
REQ-020 ram_we_o SHALL equal the granted master's we_i AND an in-range address.
REQ-021 Address is in range iff addr_i[31:2] < RAM_WORDS; an out-of-range access SHALL be granted, SHALL NOT write, and SHALL return err=1 and rdata=0.
REQ-022 FSM states are IDLE, OWN0 and OWN1; reset state is IDLE.
REQ-023 In IDLE with one requester, that master SHALL be granted; with both requesting, the master not in register last SHALL be granted (round-robin).
REQ-024 A grant with lock_i=1 SHALL move the FSM to OWNx and load burst counter cnt=1; a grant with lock_i=0 SHALL move it to IDLE.
REQ-025 In OWNx, master x SHALL have exclusive grant while req_i is high; the other master SHALL NOT be granted.
REQ-026 In OWNx, each grant SHALL increment cnt; when cnt reaches MAX_BURST and the other master's req is high, ownership SHALL be released (IDLE) regardless of lock.
REQ-027 In OWNx, if req_i is low or a grant carries lock_i=0, the FSM SHALL return to IDLE; on req_i low the other master SHALL be granted in that same cycle if requesting.
REQ-028 last SHALL update to the granted master index on every grant.
REQ-029 On a granted cycle, the granted master's rvalid, err and rdata (ram_rdata_i for an in-range read) SHALL register at the next edge; rvalid is high for exactly one cycle per grant.
REQ-030 Back-to-back grants SHALL give back-to-back rvalid pulses with no bubbles (throughput of 1 access per cycle).
REQ-031 cnt SHALL saturate at MAX_BURST and SHALL never wrap.

Reset
REQ-032 While rst_n=0: FSM=IDLE, last=1, cnt=0; all rvalid, err and rdata outputs SHALL be 0; gnt and ram_we_o SHALL be 0.
REQ-033 Reset asserted mid-burst SHALL immediately abort ownership; no response SHALL be issued for the cycle in which reset is asserted.

Verification
REQ-034 Both reqs held from reset, lock=0 -> grants alternate m0,m1,m0,...; each rvalid follows its grant by 1 cycle.
REQ-035 m1 writes 0xDEADBEEF to 0x40, then m0 reads 0x40 -> m0_rdata_o=0xDEADBEEF with rvalid one cycle after the m0 grant.
REQ-036 m1 lock=1 held for 6 accesses with m0 requesting, MAX_BURST=4 -> m1 granted 4 times, then m0 granted.
REQ-037 m0 write to 0x0000_4000 (word 4096) -> granted, ram_we_o=0, m0_err_o=1, m0_rdata_o=0.
REQ-038 rst_n driven low during OWN1 -> all outputs 0 asynchronously; after release, simultaneous reqs grant m0 first.
REQ-039 m0 alone requesting in OWN1 while m1 drops req -> m0 granted in the same cycle and FSM returns to IDLE or OWN0 per m0_lock_i.
